// File: rtl/axis_fir_mac_filter.sv
// rtl/axis_fir_mac_filter.sv - time-multiplexed AXI-Stream FIR filter with one signed MAC
//
// Purpose: filters a signed sample stream with NTAPS run-time reloadable coefficients.
//   It iterates one multiplier-accumulator over the taps for each sample.
//   The result is rounded half-up and saturated to DATA_W.
// Ports:
//   aclk, areset                      clock, synchronous active-high reset
//   s_axis_data_tvalid/tdata/tready   input samples (signed DATA_W)
//   m_axis_data_tvalid/tdata/tready   filtered output samples (signed DATA_W)
//   s_axis_cfg_tvalid/tdata/tlast/tready
//                                     coefficient load, index order 0..NTAPS-1,
//                                     tlast rewinds the write pointer
module axis_fir_mac_filter #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NTAPS     = 18,
  parameter int OUT_SHIFT = 15
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_data_tvalid,
  input  logic signed [DATA_W-1:0] s_axis_data_tdata,
  output logic                     s_axis_data_tready,
  output logic                     m_axis_data_tvalid,
  output logic signed [DATA_W-1:0] m_axis_data_tdata,
  input  logic                     m_axis_data_tready,
  input  logic                     s_axis_cfg_tvalid,
  input  logic signed [COEF_W-1:0] s_axis_cfg_tdata,
  input  logic                     s_axis_cfg_tlast,
  output logic                     s_axis_cfg_tready
);

  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);
  // Coefficients are held one bit wider than COEF_W.
  // This keeps the passthrough value 1<<OUT_SHIFT exact even when OUT_SHIFT = COEF_W-1.
  // Loaded words are sign-extended into this width.
  localparam int CW     = COEF_W + 1;
  localparam int PROD_W = DATA_W + CW;
  localparam int IDX_W  = $clog2(NTAPS);

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NTAPS - 1);
  localparam logic signed [CW-1:0]  PASS_COEF = {{(CW-1){1'b0}}, 1'b1} << OUT_SHIFT;
  localparam logic signed [ACC_W:0] HALF      = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX   = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN   = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] taps  [NTAPS];
  logic signed [CW-1:0]     coefs [NTAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         wptr;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W:0]    biased;
  logic signed [ACC_W:0]    rounded;
  logic signed [DATA_W-1:0] sat_out;

  // Config wins over data in IDLE, so a coefficient update lands before the next sample.
  assign s_axis_cfg_tready  = (state == IDLE);
  assign s_axis_data_tready = (state == IDLE) && !s_axis_cfg_tvalid;

  // One extra accumulator bit for the rounding bias.
  // An accumulator near its limit then cannot wrap before the shift.
  always_comb begin
    prod     = PROD_W'(coefs[idx]) * PROD_W'(taps[idx]);
    acc_next = acc + ACC_W'(prod);
    biased   = (ACC_W+1)'(acc_next) + HALF;
    rounded  = biased >>> OUT_SHIFT;
    if (rounded > SAT_MAX)
      sat_out = {1'b0, {(DATA_W-1){1'b1}}};
    else if (rounded < SAT_MIN)
      sat_out = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat_out = rounded[DATA_W-1:0];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state              <= IDLE;
      acc                <= '0;
      idx                <= '0;
      wptr               <= '0;
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        taps[i]  <= '0;
        coefs[i] <= '0;
      end
      coefs[0] <= PASS_COEF;
    end else begin
      case (state)
        IDLE: begin
          if (s_axis_cfg_tvalid) begin
            coefs[wptr] <= CW'(s_axis_cfg_tdata);
            wptr        <= (s_axis_cfg_tlast || wptr == LAST_IDX) ? '0 : wptr + IDX_W'(1);
          end else if (s_axis_data_tvalid) begin
            taps[0] <= s_axis_data_tdata;
            for (int i = 1; i < NTAPS; i++)
              taps[i] <= taps[i-1];
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          idx <= idx + IDX_W'(1);
          // The final product is folded in combinationally.
          // The output register is then loaded in the same cycle as the last MAC step.
          if (idx == LAST_IDX) begin
            idx                <= '0;
            m_axis_data_tvalid <= 1'b1;
            m_axis_data_tdata  <= sat_out;
            state              <= OUT;
          end
        end
        OUT: begin
          if (m_axis_data_tready) begin
            m_axis_data_tvalid <= 1'b0;
            m_axis_data_tdata  <= '0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fir_mac_filter.sv
// tb/tb_axis_fir_mac_filter.sv - scoreboard bench for axis_fir_mac_filter (NTAPS=8)
module tb_axis_fir_mac_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   sel = 1'b0;   // 0: OUT_SHIFT=15 instance, 1: OUT_SHIFT=1 instance
  logic d_tvalid = 1'b0;
  logic signed [15:0] d_tdata = '0;
  logic c_tvalid = 1'b0;
  logic signed [15:0] c_tdata = '0;
  logic c_tlast = 1'b0;
  logic m_tready = 1'b1;

  logic a_d_tready, a_c_tready, a_m_tvalid;
  logic b_d_tready, b_c_tready, b_m_tvalid;
  logic signed [15:0] a_m_tdata, b_m_tdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic signed [15:0] qa[$];
  logic signed [15:0] qb[$];

  int exp_pos[8] = '{32766, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
  int exp_neg[8] = '{32767, 32767, 32767, -4, -32768, -32768, -32768, -32768};

  wire d_tready_sel = sel ? b_d_tready : a_d_tready;
  wire c_tready_sel = sel ? b_c_tready : a_c_tready;

  axis_fir_mac_filter #(.DATA_W(16), .COEF_W(16), .NTAPS(8), .OUT_SHIFT(15)) u_dut_s15 (
    .aclk(clk), .areset(rst),
    .s_axis_data_tvalid(d_tvalid && !sel), .s_axis_data_tdata(d_tdata), .s_axis_data_tready(a_d_tready),
    .m_axis_data_tvalid(a_m_tvalid), .m_axis_data_tdata(a_m_tdata), .m_axis_data_tready(m_tready),
    .s_axis_cfg_tvalid(c_tvalid && !sel), .s_axis_cfg_tdata(c_tdata), .s_axis_cfg_tlast(c_tlast),
    .s_axis_cfg_tready(a_c_tready)
  );

  axis_fir_mac_filter #(.DATA_W(16), .COEF_W(16), .NTAPS(8), .OUT_SHIFT(1)) u_dut_s1 (
    .aclk(clk), .areset(rst),
    .s_axis_data_tvalid(d_tvalid && sel), .s_axis_data_tdata(d_tdata), .s_axis_data_tready(b_d_tready),
    .m_axis_data_tvalid(b_m_tvalid), .m_axis_data_tdata(b_m_tdata), .m_axis_data_tready(m_tready),
    .s_axis_cfg_tvalid(c_tvalid && sel), .s_axis_cfg_tdata(c_tdata), .s_axis_cfg_tlast(c_tlast),
    .s_axis_cfg_tready(b_c_tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples mid-low-phase; a valid&ready seen here completes on the next rising edge.
  initial begin
    logic stall_p [2];
    logic signed [15:0] held [2];
    logic v;
    logic signed [15:0] d;
    logic signed [15:0] e;
    stall_p[0] = 1'b0;
    stall_p[1] = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      for (int s = 0; s < 2; s++) begin
        v = (s == 1) ? b_m_tvalid : a_m_tvalid;
        d = (s == 1) ? b_m_tdata : a_m_tdata;
        if (rst) begin
          stall_p[s] = 1'b0;
        end else begin
          if (stall_p[s]) begin
            chk("hold_tvalid", v, 1);
            chk("hold_tdata", d, held[s]);
          end
          if (!v) begin
            chk("idle_tdata_zero", d, 0);
          end else if (m_tready) begin
            if (((s == 1) ? qb.size() : qa.size()) == 0) begin
              chk("unexpected_output", d, 99999);
            end else begin
              e = (s == 1) ? qb.pop_front() : qa.pop_front();
              chk((s == 1) ? "out_s1" : "out_s15", d, e);
            end
          end
          stall_p[s] = v && !m_tready;
          held[s]    = d;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; d_tvalid = 1'b0; c_tvalid = 1'b0; c_tlast = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_cfg(input bit s, input logic signed [15:0] x, input logic last);
    int n = 0;
    sel = s; c_tdata = x; c_tlast = last; c_tvalid = 1'b1;
    #2;
    while (!c_tready_sel && n < 200) begin
      @(negedge clk); #2; n++;
    end
    chk("cfg_accept_timeout", n >= 200, 0);
    @(negedge clk);
    c_tvalid = 1'b0; c_tlast = 1'b0;
  endtask

  task automatic send_data(input bit s, input logic signed [15:0] x, input logic signed [15:0] e,
                           input bit push, output int acc_cyc);
    int n = 0;
    sel = s; d_tdata = x; d_tvalid = 1'b1;
    #2;
    while (!d_tready_sel && n < 200) begin
      @(negedge clk); #2; n++;
    end
    chk("data_accept_timeout", n >= 200, 0);
    if (push && n < 200) begin
      if (s) qb.push_back(e);
      else   qa.push_back(e);
    end
    @(negedge clk);
    acc_cyc  = cyc;
    d_tvalid = 1'b0;
  endtask

  task automatic drain(input bit s);
    int n = 0;
    while (((s ? qb.size() : qa.size()) != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    chk(s ? "drain_s1" : "drain_s15", s ? qb.size() : qa.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int k, kprev, n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_m_tvalid_s15", a_m_tvalid, 0);
    chk("rst_m_tdata_s15", a_m_tdata, 0);
    chk("rst_m_tvalid_s1", b_m_tvalid, 0);
    chk("rst_s_tready_s15", a_d_tready, 1);
    chk("rst_cfg_tready_s15", a_c_tready, 1);

    // Passthrough after reset, with latency measured from the accepting edge.
    @(negedge clk);
    send_data(0, 16'sd1000, 16'sd1000, 1, k);
    n = 0;
    #2;
    while (!a_m_tvalid && n < 50) begin
      @(negedge clk); #2; n++;
    end
    chk("latency_edges", cyc - k + 1, 9);
    drain(0);
    send_data(1, -16'sd1234, -16'sd1234, 1, k);
    drain(1);

    // Ramp coefficients, impulse response, OUT_SHIFT=1.
    do_reset();
    for (int i = 0; i < 8; i++) send_cfg(1, 16'(2 * (i + 1)), i == 7);
    for (int i = 0; i < 8; i++) send_data(1, (i == 0) ? 16'sd1 : 16'sd0, 16'(i + 1), 1, k);
    drain(1);

    // Saturation in both directions.
    do_reset();
    for (int i = 0; i < 8; i++) send_cfg(0, 16'sd32767, i == 7);
    for (int i = 0; i < 8; i++) send_data(0, 16'sd32767, 16'(exp_pos[i]), 1, k);
    for (int i = 0; i < 8; i++) send_data(0, -16'sd32768, 16'(exp_neg[i]), 1, k);
    drain(0);

    // Round-half-up: partial load leaves the other coefficients at their reset zeros.
    do_reset();
    send_cfg(1, 16'sd1, 1'b1);
    send_data(1, 16'sd3, 16'sd2, 1, k);
    send_data(1, -16'sd3, -16'sd1, 1, k);
    drain(1);

    // Backpressure in OUT, then a back-to-back stream at full rate.
    do_reset();
    m_tready = 1'b0;
    send_data(0, 16'sd500, 16'sd500, 1, k);
    n = 0;
    #2;
    while (!a_m_tvalid && n < 50) begin
      @(negedge clk); #2; n++;
    end
    chk("stall_reach_out", n < 50, 1);
    repeat (5) begin
      @(negedge clk); #2;
      chk("stall_m_tvalid", a_m_tvalid, 1);
      chk("stall_s_tready", a_d_tready, 0);
      chk("stall_cfg_tready", a_c_tready, 0);
    end
    @(negedge clk);
    m_tready = 1'b1;
    drain(0);
    kprev = 0;
    for (int i = 0; i < 10; i++) begin
      send_data(0, 16'(i * 1111 - 5000), 16'(i * 1111 - 5000), 1, k);
      if (i > 0) chk("throughput_period", k - kprev, 10);
      kprev = k;
    end
    drain(0);

    // Config and data together: config takes effect before the sample (coef[0] = 0.5).
    do_reset();
    sel = 1'b0; c_tdata = 16'sd16384; c_tlast = 1'b1; c_tvalid = 1'b1;
    d_tdata = 16'sd2000; d_tvalid = 1'b1;
    #2;
    chk("prio_s_tready", d_tready_sel, 0);
    chk("prio_cfg_tready", c_tready_sel, 1);
    @(negedge clk);
    c_tvalid = 1'b0; c_tlast = 1'b0;
    #2;
    chk("prio_s_tready_after", d_tready_sel, 1);
    qa.push_back(16'sd1000);
    @(negedge clk);
    d_tvalid = 1'b0;
    drain(0);

    // Reset mid-MAC: the in-flight sample is dropped and passthrough returns.
    send_data(0, 16'sd3000, 16'sd0, 0, k);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      #2;
      chk("abort_m_tvalid", a_m_tvalid, 0);
      @(negedge clk);
    end
    send_data(0, 16'sd777, 16'sd777, 1, k);
    drain(0);

    chk("queue_s15_empty", qa.size(), 0);
    chk("queue_s1_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
